bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down counter (countdown timer). It is the decrementing counterpart of the team's decade up-counters.
- Loaded with a BCD preset, started and paused by control strobes, and decremented on each `en` tick.
- Flags `done` when the count reaches zero; supports an optional auto-reload mode.
- Sits between a tick prescaler (drives `en`) and the display/digit-mux logic (reads `bcd`).

Parameters:
- DIGITS, 4, number of BCD decades; count width is 4*DIGITS bits.
- AUTO_RELOAD, 0, 1 = on reaching zero, reload the last valid preset and keep running; 0 = stop in DONE.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  count tick strobe; acted on only in RUN.
- load  input  1  load strobe for load_val.
- load_val  input  4*DIGITS  BCD preset; nibble i is decade i, and nibble 0 is the units digit.
- start  input  1  start/resume strobe.
- pause  input  1  pause strobe.
- bcd  output  4*DIGITS  current count, registered.
- running  output  1  high while state == RUN.
- zero  output  1  combinational, bcd == 0.
- done  output  1  registered, one-cycle pulse at expiry.
- load_err  output  1  registered, one-cycle pulse on rejected load.

Behaviour:
- Reset values (asynchronous, rst_n low): bcd = 0, preset register = 0, state = IDLE, done = 0, load_err = 0. Reset mid-run aborts immediately; no done pulse is generated.
- States: IDLE, RUN, PAUSED, DONE; 2-bit encoding.
- Control priority per cycle: load > pause > start > en.
- Load:
  - Valid when every nibble of load_val is <= 9.
  - Valid load: bcd <= load_val, preset <= load_val, state <= IDLE from any state (aborts a run). All other inputs are ignored that cycle.
  - Invalid load: bcd, preset and state are unchanged; load_err = 1 for the next cycle only.
- Start:
  - IDLE or PAUSED with bcd != 0 -> RUN.
  - Ignored when bcd == 0, when already in RUN, and in DONE.
- Pause: RUN -> PAUSED; ignored in every other state.
- Decrement (RUN and en, no load/pause that cycle):
  - Decade i decrements iff all decades below it are 0 (borrow chain); decade 0 always decrements.
  - A decade at 0 that decrements wraps to 9. Example: 1000 -> 0999.
  - Latency: new value visible the cycle after the en-sampled edge.
- Expiry (RUN, en, bcd == 1 i.e. the last tick):
  - AUTO_RELOAD = 0: bcd <= 0, state <= DONE, done = 1 in the same cycle bcd first reads 0.
  - AUTO_RELOAD = 1: bcd <= preset, state stays RUN, done = 1 for one cycle. Counting never passes through 0.
- Pause and en asserted together in RUN: pause wins and no decrement occurs.
- DONE: holds bcd = 0; exits only via a valid load (-> IDLE) or reset.
- en is ignored in IDLE, PAUSED and DONE.
- No wrap below zero: the count never goes 0 -> 9…9.
- done and load_err are never held for more than one cycle.

Decomposition:
- Shared package bcd_pkg:
  - State enum type (IDLE/RUN/PAUSED/DONE).
  - BCD_MAX = 4'd9.
  - Function for the per-nibble validity check.
- Sub-module bcd_down_digit: one decade with dec_in, borrow_out (= dec_in && digit == 0), load, and load_val[3:0].
- Top level instantiates DIGITS copies in a generate loop, chaining borrow_out into the next decade's dec_in and gating the chain with RUN && en.
- The FSM, expiry detect and flags live in the top level.

Test Plan:
- DIGITS=4, AUTO_RELOAD=0: load 0x0012, start, 12 en pulses -> bcd steps 0011…0001, 0000; done high exactly one cycle with bcd = 0000; state DONE; running = 0; further en and start change nothing.
- Borrow chain: load 0x1000, start, 1 en -> bcd = 0x0999; next en -> 0x0998.
- Invalid load 0x00A3 while holding 0x0042 -> load_err = 1 for one cycle; bcd stays 0x0042; state unchanged.
- Pause/resume: load 0x0005, start, 2 en -> 0x0003; pause + en in the same cycle -> 0x0003 and PAUSED; 3 en -> still 0x0003; start, 1 en -> 0x0002.
- AUTO_RELOAD=1: load 0x0003, start, 3 en -> done pulse, bcd = 0x0003, running stays 1; 3 more en -> second done pulse.
- Start with bcd = 0 after reset -> remains IDLE. Mid-run rst_n low -> bcd = 0, IDLE, no done. Valid load during RUN -> IDLE with the new value.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type, BCD digit limit and nibble validity helper for the countdown timer.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic nibble_ok(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control strobes, preset and count/status signals of the countdown timer.
interface bcd_countdown_timer_if #(parameter int DIGITS = 4);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   bcd;
  logic                  running;
  logic                  zero;
  logic                  done;
  logic                  load_err;
  modport master (output en, load, load_val, start, pause, input bcd, running, zero, done, load_err);
  modport slave  (input en, load, load_val, start, pause, output bcd, running, zero, done, load_err);
endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD decade that decrements with 0->9 wrap and passes a borrow upward.
module bcd_down_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);
  logic [3:0] digit_q, digit_d;
  always_comb begin
    digit_d = load ? load_val : dec_in ? (digit_q == 4'd0 ? 4'd9 : digit_q - 4'd1) : digit_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= 4'd0;
    else        digit_q <= digit_d;
  end
  assign digit      = digit_q;
  assign borrow_out = dec_in && digit_q == 4'd0;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-decade BCD countdown with load/start/pause control,
// expiry pulse and optional auto-reload of the last valid preset.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_countdown_timer_if.slave  bus
);
  localparam int W = 4 * DIGITS;
  state_e         state_q, state_d;
  logic [W-1:0]   preset_q, preset_d, bcd, ld_val;
  logic           done_q, done_d, load_err_q, load_err_d;
  logic           all_ok, load_ok, tick, last, zero, reload;
  logic [DIGITS:0] chain;
  logic           unused_borrow;
  always_comb begin
    all_ok = 1'b1;
    for (int n = 0; n < DIGITS; n++) all_ok = all_ok && nibble_ok(bus.load_val[4*n+:4]);
  end
  assign zero    = bcd == '0;
  assign load_ok = bus.load && all_ok;
  assign tick    = state_q == RUN && bus.en && !bus.load && !bus.pause;
  assign last    = tick && bcd == W'(1);
  assign reload  = last && AUTO_RELOAD;
  assign ld_val  = load_ok ? bus.load_val : preset_q;
  assign chain[0] = tick;
  // Each decade borrows only when every decade below it sits at zero.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .dec_in     (chain[i]),
      .load       (load_ok || reload),
      .load_val   (ld_val[4*i+:4]),
      .digit      (bcd[4*i+:4]),
      .borrow_out (chain[i+1])
    );
  end
  assign unused_borrow = chain[DIGITS];
  always_comb begin
    state_d    = bus.load ? (all_ok ? IDLE : state_q)
               : bus.pause ? (state_q == RUN ? PAUSED : state_q)
               : (bus.start && (state_q == IDLE || state_q == PAUSED) && !zero) ? RUN
               : (last && !AUTO_RELOAD) ? DONE : state_q;
    preset_d   = load_ok ? bus.load_val : preset_q;
    done_d     = last;
    load_err_d = bus.load && !all_ok;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      preset_q   <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end
  assign bus.bcd      = bcd;
  assign bus.running  = state_q == RUN;
  assign bus.zero     = zero;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: table, directed and randomized checks of both reload modes against an integer model.
module tb_bcd_countdown_timer;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_cnt[2], m_pre[2], m_st[2];
  bit m_done[2], m_err[2];

  bcd_countdown_timer_if #(.DIGITS(4)) b0 ();
  bcd_countdown_timer_if #(.DIGITS(4)) b1 ();
  bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  typedef struct {
    logic en, load, start, pause;
    logic [15:0] lv;
    logic [15:0] eb;
    logic er, ed, ee;
  } vec_t;
  vec_t tv[$];

  function automatic int to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit is_valid(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i+:4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_st[k] = S_IDLE; m_done[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic e, ld, st, ps, input logic [15:0] lv);
    m_done[k] = 0;
    m_err[k]  = 0;
    if (ld) begin
      if (is_valid(lv)) begin
        m_cnt[k] = to_int(lv); m_pre[k] = m_cnt[k]; m_st[k] = S_IDLE;
      end else m_err[k] = 1;
    end else if (ps) begin
      if (m_st[k] == S_RUN) m_st[k] = S_PAUSED;
    end else if (st && (m_st[k] == S_IDLE || m_st[k] == S_PAUSED) && m_cnt[k] != 0) begin
      m_st[k] = S_RUN;
    end else if (e && m_st[k] == S_RUN) begin
      if (m_cnt[k] == 1) begin
        m_done[k] = 1;
        if (k == 1) m_cnt[k] = m_pre[k];
        else begin m_cnt[k] = 0; m_st[k] = S_DONE; end
      end else m_cnt[k] = m_cnt[k] - 1;
    end
  endtask

  task automatic check_models();
    chk("dut0 bcd", b0.bcd, to_bcd(m_cnt[0]));
    chk("dut0 running", 16'(b0.running), 16'(m_st[0] == S_RUN));
    chk("dut0 zero", 16'(b0.zero), 16'(m_cnt[0] == 0));
    chk("dut0 done", 16'(b0.done), 16'(m_done[0]));
    chk("dut0 load_err", 16'(b0.load_err), 16'(m_err[0]));
    chk("dut1 bcd", b1.bcd, to_bcd(m_cnt[1]));
    chk("dut1 running", 16'(b1.running), 16'(m_st[1] == S_RUN));
    chk("dut1 zero", 16'(b1.zero), 16'(m_cnt[1] == 0));
    chk("dut1 done", 16'(b1.done), 16'(m_done[1]));
    chk("dut1 load_err", 16'(b1.load_err), 16'(m_err[1]));
  endtask

  task automatic step(input logic e, ld, st, ps, input logic [15:0] lv);
    b0.en = e; b0.load = ld; b0.start = st; b0.pause = ps; b0.load_val = lv;
    b1.en = e; b1.load = ld; b1.start = st; b1.pause = ps; b1.load_val = lv;
    model_step(0, e, ld, st, ps, lv);
    model_step(1, e, ld, st, ps, lv);
    @(posedge clk);
    #1;
    check_models();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic e, ld, st, ps, input logic [15:0] lv, eb, input logic er, ed, ee);
    vec_t v;
    v.en = e; v.load = ld; v.start = st; v.pause = ps; v.lv = lv;
    v.eb = eb; v.er = er; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  initial begin
    b0.en = 0; b0.load = 0; b0.start = 0; b0.pause = 0; b0.load_val = '0;
    b1.en = 0; b1.load = 0; b1.start = 0; b1.pause = 0; b1.load_val = '0;
    model_reset();
    #1;
    check_models();
    do_reset();
    check_models();

    // Table: start at zero after reset, then 0012 counts down to expiry in stop mode.
    tv.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 16'h0012, 16'h0012, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0012, 1, 0, 0));
    for (int j = 1; j <= 11; j++) tv.push_back(mk(1, 0, 0, 0, 16'h0000, to_bcd(12 - j), 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0));
    tv.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tv.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 16'h00A3, 16'h0000, 0, 0, 1));
    foreach (tv[j]) begin
      step(tv[j].en, tv[j].load, tv[j].start, tv[j].pause, tv[j].lv);
      chk($sformatf("tbl%0d bcd", j), b0.bcd, tv[j].eb);
      chk($sformatf("tbl%0d running", j), 16'(b0.running), 16'(tv[j].er));
      chk($sformatf("tbl%0d done", j), 16'(b0.done), 16'(tv[j].ed));
      chk($sformatf("tbl%0d load_err", j), 16'(b0.load_err), 16'(tv[j].ee));
    end

    // Borrow across three decades.
    step(0, 1, 0, 0, 16'h1000);
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    chk("borrow 1000-1", b0.bcd, 16'h0999);
    step(1, 0, 0, 0, 16'h0000);
    chk("borrow 0999-1", b0.bcd, 16'h0998);

    // Rejected load leaves count and run state intact.
    step(0, 1, 0, 0, 16'h0042);
    step(0, 0, 1, 0, 16'h0000);
    step(0, 1, 0, 0, 16'h00A3);
    chk("badload err", 16'(b0.load_err), 16'h1);
    chk("badload bcd", b0.bcd, 16'h0042);
    chk("badload running", 16'(b0.running), 16'h1);
    step(0, 0, 0, 0, 16'h0000);
    chk("badload err clears", 16'(b0.load_err), 16'h0);

    // Pause beats en; paused count ignores ticks; resume continues.
    step(0, 1, 0, 0, 16'h0005);
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    chk("pause pre", b0.bcd, 16'h0003);
    step(1, 0, 0, 1, 16'h0000);
    chk("pause+en bcd", b0.bcd, 16'h0003);
    chk("pause+en running", 16'(b0.running), 16'h0);
    for (int j = 0; j < 3; j++) step(1, 0, 0, 0, 16'h0000);
    chk("paused en ignored", b0.bcd, 16'h0003);
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    chk("resume bcd", b0.bcd, 16'h0002);

    // Auto-reload instance: two expiries without passing through zero.
    step(0, 1, 0, 0, 16'h0003);
    step(0, 0, 1, 0, 16'h0000);
    for (int r = 0; r < 2; r++) begin
      step(1, 0, 0, 0, 16'h0000);
      step(1, 0, 0, 0, 16'h0000);
      step(1, 0, 0, 0, 16'h0000);
      chk($sformatf("reload%0d done", r), 16'(b1.done), 16'h1);
      chk($sformatf("reload%0d bcd", r), b1.bcd, 16'h0003);
      chk($sformatf("reload%0d running", r), 16'(b1.running), 16'h1);
    end

    // Valid load while running aborts to IDLE with the new value.
    step(0, 1, 0, 0, 16'h0030);
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    step(1, 1, 0, 0, 16'h0077);
    chk("load in run bcd", b0.bcd, 16'h0077);
    chk("load in run running", 16'(b0.running), 16'h0);

    // Asynchronous reset mid-run clears immediately and never pulses done.
    step(0, 1, 0, 0, 16'h0002);
    step(0, 0, 1, 0, 16'h0000);
    b0.en = 1; b1.en = 1;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst bcd", b0.bcd, 16'h0000);
    chk("async rst running", 16'(b0.running), 16'h0);
    @(posedge clk);
    #1;
    check_models();
    rst_n = 1'b1;
    step(1, 0, 0, 0, 16'h0000);

    // Randomized traffic on both instances against the integer model.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] lv;
      lv = '0;
      lv[3:0] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) lv[7:4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) lv[4*$urandom_range(0, 3)+:4] = 4'($urandom_range(10, 15));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, lv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
